// File: rtl/fpu_job_sequencer.sv
// Job sequencer that walks a 3-row sliding window over an image: fetch rows, run the FPU, write one result row.
// Optional build macro FPU_SEQ_PERF_EN adds a perf_cycles output counting busy cycles of the last job.
//
// state   | meaning
// IDLE    | waiting for go
// CFG     | configuration loader running, waiting for cfg_done
// FETCH   | fetching input rows until the 3-row window is full
// COMPUTE | FPU computing one output row
// WRITE   | writing the output row
// NEXT    | advance row index, decide whether the job is finished
// DONE    | one-cycle completion (done, optionally err)
module fpu_job_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              cfg_start,
  input  logic              cfg_done,
  input  logic [DIM_W-1:0]  image_width,
  input  logic [DIM_W-1:0]  image_height,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [ADDR_W-1:0] result_address,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  output logic              fpu_start,
  input  logic              fpu_done,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
`ifdef FPU_SEQ_PERF_EN
  output logic              err,
  output logic [31:0]       perf_cycles
`else
  output logic              err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_FETCH, S_COMPUTE, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] width_q;
  logic [ADDR_W-1:0] height_q;
  logic [ADDR_W-1:0] result_q;
  logic [ADDR_W-1:0] row_q;
  logic [1:0]        rows_needed;

  logic              dims_bad;
  logic [ADDR_W-1:0] row_next;
  logic [ADDR_W-1:0] out_pitch;
  logic [ADDR_W-1:0] last_row;

  assign dims_bad  = (image_width < DIM_W'(3)) || (image_height < DIM_W'(3));
  assign row_next  = row_q + ADDR_W'(1);
  assign out_pitch = width_q - ADDR_W'(2);
  assign last_row  = height_q - ADDR_W'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cfg_start   <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      fpu_start   <= 1'b0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      width_q     <= '0;
      height_q    <= '0;
      result_q    <= '0;
      row_q       <= '0;
      rows_needed <= '0;
    end else begin
      cfg_start <= 1'b0;
      fpu_start <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_CFG;
            cfg_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_CFG: begin
          if (cfg_done) begin
            width_q  <= ADDR_W'(image_width);
            height_q <= ADDR_W'(image_height);
            result_q <= result_address;
            if (dims_bad) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state       <= S_FETCH;
              rd_req      <= 1'b1;
              rd_addr     <= start_address;
              rows_needed <= 2'd3;
              row_q       <= '0;
            end
          end
        end
        S_FETCH: begin
          // A one-cycle gap with rd_req low separates consecutive row requests.
          if (!rd_req) begin
            rd_req <= 1'b1;
          end else if (rd_ack) begin
            rd_req      <= 1'b0;
            rd_addr     <= rd_addr + width_q;
            rows_needed <= rows_needed - 2'd1;
            if (rows_needed == 2'd1) begin
              state     <= S_COMPUTE;
              fpu_start <= 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (fpu_done) begin
            state   <= S_WRITE;
            wr_req  <= 1'b1;
            wr_addr <= result_q + row_q * out_pitch;
          end
        end
        S_WRITE: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            state  <= S_NEXT;
          end
        end
        S_NEXT: begin
          row_q <= row_next;
          if (row_next == last_row) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state       <= S_FETCH;
            rows_needed <= 2'd1;
            rd_req      <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FPU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (state == S_IDLE && go) begin
      perf_cycles <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_job_sequencer.sv
// Self-checking bench for fpu_job_sequencer: randomized responders plus a job-level expected-event model.
module tb_fpu_job_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        cfg_done = 1'b0;
  logic        rd_ack = 1'b0;
  logic        fpu_done = 1'b0;
  logic        wr_ack = 1'b0;
  logic [15:0] image_width = '0;
  logic [15:0] image_height = '0;
  logic [31:0] start_address = '0;
  logic [31:0] result_address = '0;
  logic        cfg_start, rd_req, fpu_start, wr_req, busy, done, err;
  logic [31:0] rd_addr, wr_addr;
`ifdef FPU_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] pcnt = '0;
`endif

  fpu_job_sequencer #(.ADDR_W(32), .DIM_W(16)) dut (
    .clk(clk), .rst(rst), .go(go),
    .cfg_start(cfg_start), .cfg_done(cfg_done),
    .image_width(image_width), .image_height(image_height),
    .start_address(start_address), .result_address(result_address),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .fpu_start(fpu_start), .fpu_done(fpu_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .busy(busy), .done(done),
`ifdef FPU_SEQ_PERF_EN
    .err(err), .perf_cycles(perf_cycles)
`else
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Job-level model: the ordered list of events a job must produce.
  typedef struct {
    int          kind;   // 0 row read, 1 fpu start, 2 row write, 3 done
    logic [31:0] addr;
    bit          e;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] obs_rd[$];
  logic [31:0] obs_wr[$];
  int          cyc = 0, done_cnt = 0, cfg_cnt = 0, c_seen = 0, cfg_done_cyc = -10;
  int          lat_fix = 0;
  bit          noise = 1'b0;

  task automatic push_job(input logic [31:0] w, input logic [31:0] h,
                          input logic [31:0] sa, input logic [31:0] ra);
    if (w < 3 || h < 3) begin
      exp_q.push_back('{3, 32'h0, 1'b1});
    end else begin
      for (int j = 0; j < int'(h) - 2; j++) begin
        if (j == 0) begin
          for (int i = 0; i < 3; i++) exp_q.push_back('{0, sa + 32'(i) * w, 1'b0});
        end else begin
          exp_q.push_back('{0, sa + 32'(j + 2) * w, 1'b0});
        end
        exp_q.push_back('{1, 32'h0, 1'b0});
        exp_q.push_back('{2, ra + 32'(j) * (w - 32'd2), 1'b0});
      end
      exp_q.push_back('{3, 32'h0, 1'b0});
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] addr, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk({nm, "_unexpected_event"}, 32'(kind), 32'hFFFF_FFFF);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, "_order"}, 32'(kind), 32'(e.kind));
    if (kind == 0 || kind == 2) chk({nm, "_addr"}, addr, e.addr);
    if (kind == 3) begin
      chk("done_err", 32'(err), 32'(e.e));
      if (e.e) chk("err_latency", 32'(cyc), 32'(cfg_done_cyc + 1));
    end
  endtask

  function automatic int get_lat();
    return (lat_fix >= 0) ? lat_fix : int'($urandom_range(3, 0));
  endfunction

  bit          p_rd, p_wr, p_fs, p_done, p_cs, p_busy, rd_real, wr_real, fpu_act, cfg_act;
  logic [31:0] p_rd_addr, p_wr_addr;
  int          rd_wait, wr_wait, fpu_wait, cfg_wait, rd_len, wr_len;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      rd_ack = 0; wr_ack = 0; fpu_done = 0; cfg_done = 0;
      p_rd = 0; p_wr = 0; p_fs = 0; p_done = 0; p_cs = 0; p_busy = 0;
      rd_real = 0; wr_real = 0; fpu_act = 0; cfg_act = 0;
`ifdef FPU_SEQ_PERF_EN
      pcnt = '0;
`endif
    end else begin
      if (rd_req || wr_req || fpu_start)
        chk("excl", 32'(rd_req) + 32'(wr_req) + 32'(fpu_start), 32'd1);
      if (rd_req || wr_req || fpu_start || cfg_start || done) chk("busy_active", 32'(busy), 32'd1);
      if (p_done) chk("busy_after_done", 32'(busy), 32'd0);

      if (rd_real) begin
        chk("rd_deassert", 32'(rd_req), 32'd0);
        if (lat_fix >= 0) chk("rd_hold_len", 32'(rd_len), 32'(lat_fix + 1));
      end else if (rd_req && p_rd) chk("rd_addr_hold", rd_addr, p_rd_addr);
      if (rd_req && !p_rd) begin
        expect_ev(0, rd_addr, "rd");
        obs_rd.push_back(rd_addr);
        rd_wait = get_lat();
        rd_len = 0;
      end

      if (wr_real) begin
        chk("wr_deassert", 32'(wr_req), 32'd0);
        if (lat_fix >= 0) chk("wr_hold_len", 32'(wr_len), 32'(lat_fix + 1));
      end else if (wr_req && p_wr) chk("wr_addr_hold", wr_addr, p_wr_addr);
      if (wr_req && !p_wr) begin
        expect_ev(2, wr_addr, "wr");
        obs_wr.push_back(wr_addr);
        wr_wait = get_lat();
        wr_len = 0;
      end

      if (fpu_start) begin
        chk("fpu_pulse", 32'(p_fs), 32'd0);
        expect_ev(1, 32'h0, "fpu");
        c_seen++;
        fpu_act = 1;
        fpu_wait = get_lat();
      end
      if (cfg_start) begin
        chk("cfg_pulse", 32'(p_cs), 32'd0);
        cfg_cnt++;
        cfg_act = 1;
        cfg_wait = get_lat();
      end
      if (done) begin
        chk("done_pulse", 32'(p_done), 32'd0);
        expect_ev(3, 32'h0, "done");
        done_cnt++;
      end else if (err) chk("err_without_done", 32'(err), 32'd0);

`ifdef FPU_SEQ_PERF_EN
      if (cfg_start) pcnt = '0;
      else if (p_busy) pcnt = pcnt + 32'd1;
      if (!busy || cfg_start) chk("perf_cycles", perf_cycles, pcnt);
`endif

      rd_real = 0; rd_ack = 0;
      if (rd_req) begin
        rd_len++;
        if (rd_wait == 0) begin rd_ack = 1; rd_real = 1; end
        else rd_wait--;
      end else if (noise && $urandom_range(3, 0) == 0) rd_ack = 1;

      wr_real = 0; wr_ack = 0;
      if (wr_req) begin
        wr_len++;
        if (wr_wait == 0) begin wr_ack = 1; wr_real = 1; end
        else wr_wait--;
      end else if (noise && $urandom_range(3, 0) == 0) wr_ack = 1;

      fpu_done = 0;
      if (fpu_act) begin
        if (fpu_wait == 0) begin fpu_done = 1; fpu_act = 0; end
        else fpu_wait--;
      end
      cfg_done = 0;
      if (cfg_act) begin
        if (cfg_wait == 0) begin cfg_done = 1; cfg_act = 0; cfg_done_cyc = cyc; end
        else cfg_wait--;
      end

      p_rd = rd_req; p_wr = wr_req; p_fs = fpu_start; p_done = done; p_cs = cfg_start;
      p_busy = busy; p_rd_addr = rd_addr; p_wr_addr = wr_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'd0);
    chk({nm, "_cfg_start"}, 32'(cfg_start), 32'd0);
    chk({nm, "_rd_req"}, 32'(rd_req), 32'd0);
    chk({nm, "_fpu_start"}, 32'(fpu_start), 32'd0);
    chk({nm, "_wr_req"}, 32'(wr_req), 32'd0);
    chk({nm, "_rd_addr"}, rd_addr, 32'd0);
    chk({nm, "_wr_addr"}, wr_addr, 32'd0);
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 3000 && done_cnt < target; k++) tick();
    if (done_cnt < target) chk("done_timeout", 32'(done_cnt), 32'(target));
  endtask

  task automatic start_job(input logic [15:0] w, input logic [15:0] h,
                           input logic [31:0] sa, input logic [31:0] ra);
    image_width = w; image_height = h; start_address = sa; result_address = ra;
    push_job(32'(w), 32'(h), sa, ra);
    obs_rd.delete(); obs_wr.delete(); c_seen = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] w, input logic [15:0] h,
                         input logic [31:0] sa, input logic [31:0] ra);
    int base;
    base = done_cnt;
    start_job(w, h, sa, ra);
    wait_done(base + 1);
    tick();
  endtask

  logic [31:0] lit_rd[5];
  logic [31:0] lit_wr[3];

  initial begin
    int base, cb;
    lit_rd = '{32'h2000, 32'h2005, 32'h200A, 32'h200F, 32'h2014};
    lit_wr = '{32'h3000, 32'h3003, 32'h3006};

    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 5x5 image with instant acks: literal addresses pin the model too.
    lat_fix = 0;
    run_job(16'd5, 16'd5, 32'h2000, 32'h3000);
    chk("basic_rd_count", 32'(obs_rd.size()), 32'd5);
    for (int i = 0; i < obs_rd.size() && i < 5; i++) chk("basic_rd_lit", obs_rd[i], lit_rd[i]);
    chk("basic_wr_count", 32'(obs_wr.size()), 32'd3);
    for (int i = 0; i < obs_wr.size() && i < 3; i++) chk("basic_wr_lit", obs_wr[i], lit_wr[i]);
    chk("basic_fpu_count", 32'(c_seen), 32'd3);

    // Illegal width: only done+err.
    lat_fix = -1;
    run_job(16'd2, 16'd10, 32'h4000, 32'h5000);
    chk("illegal_rd_count", 32'(obs_rd.size()), 32'd0);
    chk("illegal_fpu_count", 32'(c_seen), 32'd0);

    // Slow acks: hold and deassert timing.
    lat_fix = 4;
    run_job(16'd4, 16'd3, 32'h0100, 32'h0800);

    // Reset while computing row 1, then restart.
    lat_fix = 5;
    start_job(16'd6, 16'd6, 32'h7000, 32'h9000);
    for (int k = 0; k < 500 && c_seen < 2; k++) tick();
    chk("midrst_reached_row1", 32'(c_seen), 32'd2);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    tick();
    lat_fix = -1;
    run_job(16'd6, 16'd6, 32'h7000, 32'h9000);
    chk("restart_first_rd", (obs_rd.size() > 0) ? obs_rd[0] : 32'hDEAD_BEEF, 32'h7000);

    // go held high across a 3x3 job: a second job follows.
    image_width = 16'd3; image_height = 16'd3; start_address = 32'hA000; result_address = 32'hB000;
    push_job(32'd3, 32'd3, 32'hA000, 32'hB000);
    push_job(32'd3, 32'd3, 32'hA000, 32'hB000);
    obs_rd.delete(); obs_wr.delete();
    base = done_cnt; cb = cfg_cnt;
    go = 1'b1;
    wait_done(base + 2);
    go = 1'b0;
    repeat (4) tick();
    chk("goheld_cfg_starts", 32'(cfg_cnt - cb), 32'd2);
    chk("goheld_wr_count", 32'(obs_wr.size()), 32'd2);

    // Fixed 2-cycle latencies on a 4x4 image, plus an address-wrap job.
    lat_fix = 2;
    run_job(16'd4, 16'd4, 32'h0C00, 32'h0D00);
    lat_fix = -1;
    run_job(16'd7, 16'd4, 32'hFFFF_FFF0, 32'hFFFF_FFFC);

    // Random jobs with stray acks outside the request windows.
    noise = 1'b1;
    for (int j = 0; j < 12; j++)
      run_job(16'($urandom_range(9, 0)), 16'($urandom_range(9, 0)), $urandom, $urandom);
    noise = 1'b0;
    repeat (5) tick();
    chk("model_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
